// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Used by pc_seq and pc_ras; PC_SEQ_RAS_EN selects the return-address stack build.
package pc_pkg;

    localparam int PC_AW = 16;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        INC    = 3'd1,
        LOAD   = 3'd2,
        BRANCH = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5,
        CLEAR  = 3'd6
    } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of AW-bit entries with occupancy count.
// Only instantiated when PC_SEQ_RAS_EN is defined; storage carries no reset.
module pc_ras
    import pc_pkg::*;
#(
    parameter int AW    = PC_AW,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] data_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

    // Write slot is the current count; the top entry sits one below it.
    assign wr_idx  = IW'(cnt_q);
    assign rd_idx  = IW'(cnt_q - CW'(1));
    assign data_o  = mem_q[rd_idx];

    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i & ~push_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (do_push) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with registered pc_addr and optional call/return stack.
// Define PC_SEQ_RAS_EN to build in pc_ras; otherwise CALL acts as LOAD and RET as HOLD.
module pc_seq
    import pc_pkg::*;
#(
    parameter int            AW         = PC_AW,
    parameter int            RAS_DEPTH  = 8,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  pc_op_t                           op,
    input  logic [AW-1:0]                    target,
    input  logic [AW-1:0]                    offset,
    output logic [AW-1:0]                    pc_addr,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             err
);

    localparam int CNTW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_inc;

    assign pc_inc  = pc_q + AW'(1);
    assign pc_addr = pc_q;

`ifdef PC_SEQ_RAS_EN
    logic            err_q, err_d;
    logic            ras_push, ras_pop, ras_clr;
    logic [AW-1:0]   ras_top;
    logic [CNTW-1:0] ras_cnt_w;
    logic            ras_full_w, ras_empty_w;

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH),
        .CW    (CNTW)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .clear_i (ras_clr),
        .data_i  (pc_inc),
        .data_o  (ras_top),
        .cnt_o   (ras_cnt_w),
        .full_o  (ras_full_w),
        .empty_o (ras_empty_w)
    );

    assign ras_cnt   = ras_cnt_w;
    assign ras_full  = ras_full_w;
    assign ras_empty = ras_empty_w;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign ras_cnt   = '0;
    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign err       = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
`ifdef PC_SEQ_RAS_EN
        err_d    = err_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ras_clr  = 1'b0;
`endif
        if (en) begin
            case (op)
                INC:    pc_d = pc_inc;
                LOAD:   pc_d = target;
                BRANCH: pc_d = pc_q + offset;
                CLEAR: begin
                    pc_d = RESET_ADDR;
`ifdef PC_SEQ_RAS_EN
                    err_d   = 1'b0;
                    ras_clr = 1'b1;
`endif
                end
`ifdef PC_SEQ_RAS_EN
                // Faulting CALL/RET leave pc and stack alone and only raise err.
                CALL: begin
                    if (ras_full_w) begin
                        err_d = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                        pc_d     = target;
                    end
                end
                RET: begin
                    if (ras_empty_w) begin
                        err_d = 1'b1;
                    end else begin
                        ras_pop = 1'b1;
                        pc_d    = ras_top;
                    end
                end
`else
                CALL:   pc_d = target;
`endif
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: vector table, directed call/return cases, random vs queue model.
// Follows the PC_SEQ_RAS_EN setting of the build for its expectations.
module tb_pc_seq;
    import pc_pkg::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        en;
    pc_op_t      op;
    logic [15:0] target;
    logic [15:0] offset;
    logic [15:0] pc_addr;
    logic [3:0]  ras_cnt;
    logic        ras_full;
    logic        ras_empty;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stk [$];
    logic        m_err;

    pc_seq #(.AW(16), .RAS_DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .pc_addr   (pc_addr),
        .ras_cnt   (ras_cnt),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r;
        logic        e;
        logic [2:0]  o;
        logic [15:0] t;
        logic [15:0] f;
        logic [15:0] exp_pc;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a queue as the stack, plain 16-bit arithmetic for the pc.
    task automatic model_step(input logic r, input logic e, input logic [2:0] o,
                              input logic [15:0] t, input logic [15:0] f);
        if (r) begin
            m_pc = 16'h0000;
            m_stk.delete();
            m_err = 1'b0;
        end else if (e) begin
            case (o)
                3'd1: m_pc = m_pc + 16'd1;
                3'd2: m_pc = t;
                3'd3: m_pc = m_pc + f;
`ifdef PC_SEQ_RAS_EN
                3'd4: begin
                    if (m_stk.size() == DEPTH) m_err = 1'b1;
                    else begin
                        m_stk.push_back(m_pc + 16'd1);
                        m_pc = t;
                    end
                end
                3'd5: begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else m_pc = m_stk.pop_back();
                end
`else
                3'd4: m_pc = t;
`endif
                3'd6: begin
                    m_pc = 16'h0000;
                    m_stk.delete();
                    m_err = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] o,
                         input logic [15:0] t, input logic [15:0] f);
        rst    = r;
        en     = e;
        op     = pc_op_t'(o);
        target = t;
        offset = f;
        @(posedge clk);
        #1;
        model_step(r, e, o, t, f);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    32'(pc_addr),   32'(m_pc));
        chk({tag, ".cnt"},   32'(ras_cnt),   32'(m_stk.size()));
        chk({tag, ".full"},  32'(ras_full),  32'(m_stk.size() == DEPTH));
        chk({tag, ".empty"}, 32'(ras_empty), 32'(m_stk.size() == 0));
        chk({tag, ".err"},   32'(err),       32'(m_err));
    endtask

    vec_t tbl [15];

    initial begin
        rst = 1'b1; en = 1'b0; op = HOLD; target = '0; offset = '0;
        m_pc = '0; m_err = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0001, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0002, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0003, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000, 16'h0003, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 3'd2, 16'h1234, 16'h0000, 16'h0003, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 16'h0010, 16'h0000, 16'h0010, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd3, 16'h0000, 16'hFFF8, 16'h0008, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'd2, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'd7, 16'hABCD, 16'h0001, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd3, 16'h0000, 16'h0005, 16'h0005, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 16'h5555, 16'h0003, 16'h0005, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 3'd3, 16'h0000, 16'h7FFF, 16'h8004, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 3'd6, 16'h0000, 16'h0000, 16'h0000, 1'b0};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].o, tbl[i].t, tbl[i].f);
            chk($sformatf("tbl%0d.pc", i), 32'(pc_addr), 32'(tbl[i].exp_pc));
            chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d.cnt", i), 32'(ras_cnt), 32'd0);
        end

`ifdef PC_SEQ_RAS_EN
        drive(1'b0, 1'b1, 3'd2, 16'h0020, 16'h0000);
        drive(1'b0, 1'b1, 3'd4, 16'h0100, 16'h0000);
        chk("call.pc", 32'(pc_addr), 32'h0100);
        chk("call.cnt", 32'(ras_cnt), 32'd1);
        drive(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
        chk("ret.pc", 32'(pc_addr), 32'h0021);
        chk("ret.cnt", 32'(ras_cnt), 32'd0);
        drive(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
        chk("ret_empty.pc", 32'(pc_addr), 32'h0021);
        chk("ret_empty.err", 32'(err), 32'd1);
        drive(1'b0, 1'b1, 3'd4, 16'h0055, 16'h0000);
        chk("call_sticky.pc", 32'(pc_addr), 32'h0055);
        chk("call_sticky.err", 32'(err), 32'd1);
        drive(1'b1, 1'b1, 3'd4, 16'h0777, 16'h0000);
        chk("rst_mid.pc", 32'(pc_addr), 32'h0000);
        chk("rst_mid.cnt", 32'(ras_cnt), 32'd0);
        chk("rst_mid.err", 32'(err), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 3'd4, 16'(i * 256), 16'h0000);
            chk($sformatf("fill%0d.cnt", i), 32'(ras_cnt), 32'(i));
        end
        chk("fill.full", 32'(ras_full), 32'd1);
        drive(1'b0, 1'b1, 3'd4, 16'h0900, 16'h0000);
        chk("ovf.pc", 32'(pc_addr), 32'h0800);
        chk("ovf.full", 32'(ras_full), 32'd1);
        chk("ovf.err", 32'(err), 32'd1);
        chk("ovf.cnt", 32'(ras_cnt), 32'd8);
        drive(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
        chk("unwind.pc", 32'(pc_addr), 32'h0701);
        drive(1'b0, 1'b1, 3'd6, 16'h0000, 16'h0000);
        chk("clear.pc", 32'(pc_addr), 32'h0000);
        chk("clear.cnt", 32'(ras_cnt), 32'd0);
        chk("clear.err", 32'(err), 32'd0);
        chk("clear.empty", 32'(ras_empty), 32'd1);
`else
        drive(1'b0, 1'b1, 3'd4, 16'h0040, 16'h0000);
        chk("norас_call.pc", 32'(pc_addr), 32'h0040);
        chk("noras_call.cnt", 32'(ras_cnt), 32'd0);
        drive(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
        chk("noras_ret.pc", 32'(pc_addr), 32'h0040);
        chk("noras_ret.err", 32'(err), 32'd0);
        chk("noras_ret.empty", 32'(ras_empty), 32'd1);
        chk("noras_ret.full", 32'(ras_full), 32'd0);
`endif
        chk_model("directed_end");

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] sel;
            logic [2:0] o;
            logic       r;
            logic       e;
            sel = 4'($urandom_range(0, 15));
            case (sel)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4: o = 3'd4;
                4'd5, 4'd6, 4'd7:             o = 3'd5;
                4'd8, 4'd9:                   o = 3'd1;
                4'd10:                        o = 3'd2;
                4'd11:                        o = 3'd3;
                4'd12:                        o = 3'd0;
                4'd13:                        o = 3'd7;
                4'd14:                        o = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'd1;
                default:                      o = 3'd1;
            endcase
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            drive(r, e, o, 16'($urandom), 16'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
